spi_shiftout_reg: RTL

//  Transmit-side shift register for the SPI data path (MISO direction).
//  - Accepts parallel bytes through a valid/ready load handshake into a one-entry holding buffer.
//  - Serialises each byte MSB-first on dout, advancing one bit per shift_en strobe.
//  - Pairs with the MOSI shift-in register: both see the same shift_en strobe.
//  - The holding buffer permits back-to-back words with no gap.

---
 rtl/spi_shiftout_reg_if.sv | 41 ++++
 rtl/spi_shiftout_reg.sv | 119 +++++++++++
 2 files changed

// File: rtl/spi_shiftout_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_shiftout_reg_if
// Purpose  : Load handshake and serial-side signals of the MISO shift-out register.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_shiftout_reg_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_ready;
    logic                  shift_en;
    logic                  dout;
    logic                  busy;
    logic                  done;
    logic                  underrun;

    modport master (
        output load_valid,
        output load_data,
        output shift_en,
        input  load_ready,
        input  dout,
        input  busy,
        input  done,
        input  underrun
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  shift_en,
        output load_ready,
        output dout,
        output busy,
        output done,
        output underrun
    );
endinterface
`default_nettype wire

// File: rtl/spi_shiftout_reg.sv
`default_nettype none
// ============================================================================
// Module   : spi_shiftout_reg
// Purpose  : MISO-side MSB-first shift register with a one-word holding buffer.
// Revision : 1.0 - initial release
// ============================================================================
module spi_shiftout_reg #(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_shiftout_reg_if.slave    bus
);
    localparam int                 c_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_sreg;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_hold_full;
    logic                  r_load_ready;
    logic                  r_done;
    logic                  r_underrun;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_sreg_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic                  w_take;
    logic                  w_done_nxt;
    logic                  w_underrun_nxt;
    logic                  w_accept;
    logic                  w_hold_full_nxt;

    // Accept and take are mutually exclusive: one needs the buffer empty, the other full.
    assign w_accept        = bus.load_valid && r_load_ready;
    assign w_hold_full_nxt = w_take ? 1'b0 : (w_accept ? 1'b1 : r_hold_full);

    always_comb begin
        w_state_nxt    = r_state;
        w_sreg_nxt     = r_sreg;
        w_cnt_nxt      = r_cnt;
        w_take         = 1'b0;
        w_done_nxt     = 1'b0;
        w_underrun_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_underrun_nxt = bus.shift_en;
                if (r_hold_full) begin
                    w_sreg_nxt  = r_hold_data;
                    w_cnt_nxt   = '0;
                    w_take      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.shift_en) begin
                    if (r_cnt == c_LAST) begin
                        w_done_nxt = 1'b1;
                        if (r_hold_full) begin
                            // Chain straight into the next word so the bit stream has no gap.
                            w_sreg_nxt = r_hold_data;
                            w_cnt_nxt  = '0;
                            w_take     = 1'b1;
                        end else begin
                            w_sreg_nxt  = {DATA_WIDTH{IDLE_LEVEL}};
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_sreg_nxt = {r_sreg[DATA_WIDTH-2:0], 1'b0};
                        w_cnt_nxt  = r_cnt + c_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_sreg_nxt  = {DATA_WIDTH{IDLE_LEVEL}};
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_sreg       <= {DATA_WIDTH{IDLE_LEVEL}};
            r_cnt        <= '0;
            r_hold_data  <= '0;
            r_hold_full  <= 1'b0;
            r_load_ready <= 1'b1;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sreg       <= w_sreg_nxt;
            r_cnt        <= w_cnt_nxt;
            r_hold_full  <= w_hold_full_nxt;
            r_load_ready <= !w_hold_full_nxt;
            r_done       <= w_done_nxt;
            r_underrun   <= w_underrun_nxt;
            if (w_accept) begin
                r_hold_data <= bus.load_data;
            end
        end
    end

    assign bus.load_ready = r_load_ready;
    assign bus.dout       = r_sreg[DATA_WIDTH-1];
    assign bus.busy       = (r_state == S_SHIFT);
    assign bus.done       = r_done;
    assign bus.underrun   = r_underrun;

endmodule
`default_nettype wire
